// File: rtl/ddr_mba_arb_if.sv
// MBA bus bundle: one command/strobe/data channel between a bus master
// (request side) and a bus slave (acknowledge side).
interface ddr_mba_arb_if #(
  parameter int P_DW = 128,
  parameter int P_SW = P_DW / 8
);
  logic            req;   // command request, active-low
  logic            rel;   // request acknowledge
  logic            nel;   // request permission
  logic            rzw;   // direction, 0 = write
  logic [27:0]     adr;   // word address [29:2]
  logic [7:0]      bst;   // word count minus 1
  logic            wak;   // write-data enable, active-low
  logic [P_DW-1:0] rdt;   // write data (master to slave)
  logic [P_SW-1:0] ben;   // byte enable, active-low
  logic            rak;   // read-data enable, active-low
  logic [P_DW-1:0] wdt;   // read data (slave to master)

  modport master (
    output req, rzw, adr, bst, rdt, ben,
    input  rel, nel, wak, rak, wdt
  );

  modport slave (
    input  req, rzw, adr, bst, rdt, ben,
    output rel, nel, wak, rak, wdt
  );
endinterface

// File: rtl/ddr_mba_arb.sv
// Two-requester round-robin arbiter for the MBA memory bus. One command is
// granted at a time and the grant is held until its whole data phase
// (bst+1 beats) has completed; a single IDLE bubble always follows.
module ddr_mba_arb #(
  parameter int P_DW = 128,
  parameter int P_SW = P_DW / 8
) (
  input  logic             clk,
  input  logic             rst,
  ddr_mba_arb_if.slave     s0,
  ddr_mba_arb_if.slave     s1,
  ddr_mba_arb_if.master    m,
  output logic             gnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state;
  logic [7:0]      cnt;

  logic            elig0;
  logic            elig1;
  logic            pick;
  logic            beat;
  logic            in_cmd;
  logic            in_data;
  logic [P_DW-1:0] rdt_mux;
  logic [P_SW-1:0] ben_mux;

  // Eligibility, round-robin winner and data-beat detection.
  always_comb begin
    elig0 = ~s0.req & m.nel;
    elig1 = ~s1.req & m.nel;
    if (elig0 && elig1) begin
      pick = ~gnt;            // contention: the requester not served last
    end else if (elig0) begin
      pick = 1'b0;
    end else begin
      pick = 1'b1;
    end
    // Direction of the granted command selects which strobe carries beats.
    beat = m.rzw ? ~m.rak : ~m.wak;
  end

  // Grant FSM with registered command outputs and the beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b1;              // S0 wins the first contention
      m.req <= 1'b1;
      m.rzw <= 1'b0;
      m.adr <= 28'd0;
      m.bst <= 8'd0;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            gnt   <= pick;
            m.rzw <= pick ? s1.rzw : s0.rzw;
            m.adr <= pick ? s1.adr : s0.adr;
            m.bst <= pick ? s1.bst : s0.bst;
            cnt   <= pick ? s1.bst : s0.bst;
            m.req <= 1'b0;
            state <= CMD;
          end
        end
        CMD: begin
          if (m.rel) begin
            m.req <= 1'b1;
            state <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (cnt == 8'd0) begin
              state <= IDLE;      // last beat; next cycle is the bubble
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          m.req <= 1'b1;
        end
      endcase
    end
  end

  assign in_cmd  = (state == CMD);
  assign in_data = (state == DATA);
  assign busy    = (state != IDLE);

  // Acknowledge goes only to the granted requester, in the M_REL cycle.
  assign s0.rel = in_cmd & m.rel & ~gnt;
  assign s1.rel = in_cmd & m.rel &  gnt;

  // Permission while idle, or to the owner while its command is pending.
  assign s0.nel = m.nel & ((state == IDLE) | (in_cmd & ~gnt));
  assign s1.nel = m.nel & ((state == IDLE) | (in_cmd &  gnt));

  // Strobes reach only the granted requester, and only during the data phase.
  assign s0.wak = ~(in_data & ~gnt) | m.wak;
  assign s1.wak = ~(in_data &  gnt) | m.wak;
  assign s0.rak = ~(in_data & ~gnt) | m.rak;
  assign s1.rak = ~(in_data &  gnt) | m.rak;

  // Read data is broadcast; the RAK strobe tells the owner when it is valid.
  assign s0.wdt = m.wdt;
  assign s1.wdt = m.wdt;

  // Write data and byte enables follow the current grant.
  assign rdt_mux = gnt ? s1.rdt : s0.rdt;
  assign ben_mux = gnt ? s1.ben : s0.ben;
  assign m.rdt   = rdt_mux;
  assign m.ben   = ben_mux;

endmodule

// File: doc/ddr_mba_arb.md
Name: ddr_mba_arb

Overview:
- Two-requester arbiter/scheduler for the MBA memory bus.
- Two AXI-to-MBA bridges connect to the S0/S1 upstream ports. The block shares one downstream MBA master port (M_*) towards the DDR controller.
- Grants are round-robin, one command at a time. A grant is held until the full data phase (BST+1 beats) has completed.
- The block muxes command and write data to M_*, routes the WAK/RAK strobes back to the granted requester, and broadcasts read data to both requesters.

Parameters:
- P_DW, 128, data width of RDT/WDT.
- P_SW, P_DW/8, width of BEN.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset, asynchronous, active-high
- Sn_REQ  in  1  requester n command request, active-low (n = 0, 1; same for all Sn_* ports)
- Sn_REL  out  1  request acknowledge pulse to requester n, active-high
- Sn_NEL  out  1  request permission to requester n, active-high
- Sn_RZW  in  1  direction of requester n command, 0 = write
- Sn_ADR  in  28  [29:2] address
- Sn_BST  in  8  [9:2] word count minus 1
- Sn_WAK  out  1  write-data enable to requester n, active-low
- Sn_RDT  in  P_DW  write data from requester n
- Sn_BEN  in  P_SW  byte enable from requester n, active-low
- Sn_RAK  out  1  read-data enable to requester n, active-low
- Sn_WDT  out  P_DW  read data to requester n
- M_REQ  out  1  downstream request, active-low
- M_REL  in  1  downstream acknowledge
- M_NEL  in  1  downstream permission
- M_RZW  out  1  downstream direction
- M_ADR  out  28  downstream address
- M_BST  out  8  downstream word count minus 1
- M_WAK  in  1  downstream write-data enable, active-low
- M_RDT  out  P_DW  downstream write data
- M_BEN  out  P_SW  downstream byte enable, active-low
- M_RAK  in  1  downstream read-data enable, active-low
- M_WDT  in  P_DW  downstream read data
- GNT  out  1  index of the current or last granted requester
- BUSY  out  1  high when state is not IDLE

Behaviour:
- State machine: IDLE -> CMD -> DATA -> IDLE, held in 2-bit state register.
- IDLE:
  - Requester n is eligible when Sn_REQ=0 and M_NEL=1.
  - One eligible: grant it.
  - Both eligible: grant the requester != GNT (round-robin).
  - On grant, register GNT, latch RZW/ADR/BST from the winner into M_RZW/M_ADR/M_BST, and load cnt=BST (8 bits). Next state is CMD.
- CMD:
  - M_REQ=0 (registered; asserted the cycle after the grant decision).
  - On M_REL=1: S[GNT]_REL=1 in the same cycle (combinational). Next state is DATA, and M_REQ returns to 1 on the next cycle.
- DATA:
  - A beat is M_WAK=0 when M_RZW=0, or M_RAK=0 when M_RZW=1.
  - Each beat decrements cnt. A beat with cnt==0 is the last; next state is IDLE.
  - The downstream guarantees no beat in the M_REL cycle. Beats outside DATA are ignored and do not affect cnt.
- Total beats per grant = BST+1, range 1..256; BST=0 means a single beat.
- After the last beat there is always one IDLE cycle before the next grant (fixed bubble).
- Strobe routing:
  - S[GNT]_WAK = M_WAK and S[GNT]_RAK = M_RAK only in DATA; otherwise 1.
  - The non-granted requester always sees WAK=RAK=1.
- Datapath muxing (combinational, selected by GNT): M_RDT = S[GNT]_RDT, M_BEN = S[GNT]_BEN.
- S0_WDT = S1_WDT = M_WDT (broadcast; RAK qualifies the data).
- Sn_NEL = M_NEL & (state==IDLE | (state==CMD & GNT==n)).
- Sn_REL is 0 for the non-granted requester.
- A requester that raises REQ before its REL is still served; the command is latched at grant.
- Reset values: state IDLE, GNT=1 (so S0 wins first contention), M_REQ=1, M_RZW=0, M_ADR=0, M_BST=0, cnt=0, BUSY=0. Combinational outputs follow from these: all Sn_REL=0, all Sn_WAK/Sn_RAK=1.
- RESET asserted mid-transfer: immediate return to IDLE with the values above. The partial burst is abandoned, no acknowledge is issued, and the downstream is reset by the same RESET.

Test Plan:
- S0 write, BST=3; M_REL 2 cycles after M_REQ=0; 4 WAK beats -> S0_REL pulse once, S0_WAK low 4 cycles, S1_WAK stays 1, M_RDT tracks S0_RDT, BUSY drops after beat 4, then 1 IDLE bubble.
- S0 and S1 request together from reset, both BST=0 -> S0 granted first (GNT=0), S1 granted after the 1-cycle bubble (GNT=1); then S0 re-requests against S1 -> S0 wins.
- S1 read, BST=255, RAK bursty (every 2nd cycle) -> exactly 256 beats routed to S1_RAK, S0_RAK=1 throughout, return to IDLE on beat 256.
- M_NEL=0 while S0_REQ=0 -> no grant, M_REQ=1, S0_NEL=0; M_NEL=1 -> grant the next cycle.
- Spurious M_WAK=0 in IDLE and CMD -> ignored; cnt unchanged; no Sn_WAK asserted.
- RESET pulse during DATA beat 2 of 8 -> M_REQ=1, BUSY=0, GNT=1 immediately; a subsequent S1 request is served normally.
